// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle of the RV32I instruction encoder.
//   Request side : in_valid, in_ready, op, rd, rs1, rs2, imm
//   Output side  : out_valid, out_ready, out_instr, out_addr
//   Status       : rej (one-cycle reject pulse), err (sticky), full (capacity used up)
// master = request producer / memory writer, slave = the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [31:0]           imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  rej;
    logic                  err;
    logic                  full;

    modport master (
        output in_valid, op, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, rej, err, full
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, rej, err, full
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: range-checks symbolic RV32I requests and packs them into
// 32-bit machine words emitted with sequential word addresses.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : instr_encoder_if.slave (request handshake, output word, rej/err/full)
// Single-entry output register with pass-through drain; in_ready is combinational.
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_ORI  = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_SLLI = 5'd10;
    localparam logic [4:0] OP_SRLI = 5'd11;
    localparam logic [4:0] OP_SLTI = 5'd12;
    localparam logic [4:0] OP_LW   = 5'd13;
    localparam logic [4:0] OP_SW   = 5'd14;
    localparam logic [4:0] OP_BEQ  = 5'd15;
    localparam logic [4:0] OP_BNE  = 5'd16;
    localparam logic [4:0] OP_BLT  = 5'd17;
    localparam logic [4:0] OP_BGE  = 5'd18;
    localparam logic [4:0] OP_JAL  = 5'd19;
    localparam logic [4:0] OP_JALR = 5'd20;
    localparam logic [4:0] OP_LUI  = 5'd21;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    logic [31:0]           imm;
    logic [4:0]            rd, rs1, rs2;
    logic                  i_ok, sh_ok, b_ok, j_ok, u_ok;
    logic [31:0]           word;
    logic                  legal;

    logic                  in_ready_c;
    logic                  accept;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  rej_q,       rej_d;
    logic                  err_q,       err_d;

    // Immediate range checks: sign-uniform upper bits means the value fits.
    always_comb begin
        imm   = bus.imm;
        rd    = bus.rd;
        rs1   = bus.rs1;
        rs2   = bus.rs2;
        i_ok  = (imm[31:11] == '0) || (imm[31:11] == '1);
        sh_ok = (imm[31:5] == '0);
        b_ok  = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
        j_ok  = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
        u_ok  = (imm[11:0] == '0);
    end

    // Field packing per mnemonic; legal drops for bad immediates or unknown op.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (bus.op)
            OP_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            OP_SUB:  word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
            OP_OR:   word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
            OP_AND:  word = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
            OP_SLL:  word = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R};
            OP_SRL:  word = {7'b0000000, rs2, rs1, 3'b101, rd, OPC_R};
            OP_SLT:  word = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R};
            OP_ADDI: begin word = {imm[11:0], rs1, 3'b000, rd, OPC_I}; legal = i_ok; end
            OP_ORI:  begin word = {imm[11:0], rs1, 3'b110, rd, OPC_I}; legal = i_ok; end
            OP_ANDI: begin word = {imm[11:0], rs1, 3'b111, rd, OPC_I}; legal = i_ok; end
            OP_SLTI: begin word = {imm[11:0], rs1, 3'b010, rd, OPC_I}; legal = i_ok; end
            OP_SLLI: begin word = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OPC_I}; legal = sh_ok; end
            OP_SRLI: begin word = {7'b0000000, imm[4:0], rs1, 3'b101, rd, OPC_I}; legal = sh_ok; end
            OP_LW:   begin word = {imm[11:0], rs1, 3'b010, rd, OPC_LW}; legal = i_ok; end
            OP_SW:   begin word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_SW}; legal = i_ok; end
            OP_BEQ:  begin word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B}; legal = b_ok; end
            OP_BNE:  begin word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_B}; legal = b_ok; end
            OP_BLT:  begin word = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], OPC_B}; legal = b_ok; end
            OP_BGE:  begin word = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], OPC_B}; legal = b_ok; end
            OP_JAL:  begin word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL}; legal = j_ok; end
            OP_JALR: begin word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR}; legal = i_ok; end
            OP_LUI:  begin word = {imm[31:12], rd, OPC_LUI}; legal = u_ok; end
            default: legal = 1'b0;
        endcase
    end

    // Accept whenever the output slot is empty or draining on this edge.
    always_comb begin
        in_ready_c = !rst && !cnt_q[ADDR_WIDTH] && (!out_valid_q || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
    end

    // Next-state: rejects only touch rej/err; legal words load the output slot.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        cnt_d       = cnt_q;
        rej_d       = 1'b0;
        err_d       = err_q;
        if (accept && !legal) begin
            rej_d = 1'b1;
            err_d = 1'b1;
        end
        if (accept && legal) begin
            out_valid_d = 1'b1;
            out_instr_d = word;
            out_addr_d  = cnt_q[ADDR_WIDTH-1:0];
            cnt_d       = cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            cnt_q       <= '0;
            rej_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            rej_q       <= rej_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.rej       = rej_q;
    assign bus.err       = err_q;
    assign bus.full      = cnt_q[ADDR_WIDTH];
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a
// field-placement reference model. dut_a uses ADDR_WIDTH=8, dut_b ADDR_WIDTH=2.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   next_addr_a = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(8)) ifa ();
    instr_encoder_if #(.ADDR_WIDTH(2)) ifb ();

    instr_encoder #(.ADDR_WIDTH(8)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    instr_encoder #(.ADDR_WIDTH(2)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int r_f3 [7] = '{0, 0, 6, 7, 1, 5, 2};
    int i_f3 [6] = '{0, 6, 7, 1, 5, 2};
    int b_f3 [4] = '{0, 1, 4, 5};

    // Reference encoder built from numeric ranges and shifted field values.
    function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                       input logic [31:0] imm, output logic [31:0] w, output bit ok);
        logic signed [31:0] s;
        logic [31:0] f_rd, f_rs1, f_rs2, f_i, bf, jf;
        bit i_ok;
        s     = imm;
        i_ok  = (s >= -2048) && (s <= 2047);
        f_rd  = 32'(rd) << 7;
        f_rs1 = 32'(rs1) << 15;
        f_rs2 = 32'(rs2) << 20;
        f_i   = (imm & 32'hFFF) << 20;
        bf    = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        jf    = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        w  = 32'h0;
        ok = 1'b0;
        if (op >= 0 && op <= 6) begin
            w  = 32'h33 | f_rd | (32'(r_f3[op]) << 12) | f_rs1 | f_rs2 | ((op == 1) ? 32'h4000_0000 : 32'h0);
            ok = 1'b1;
        end else if (op == 10 || op == 11) begin
            w  = 32'h13 | f_rd | (32'(i_f3[op-7]) << 12) | f_rs1 | ((imm & 32'h1F) << 20);
            ok = (imm < 32'd32);
        end else if (op >= 7 && op <= 12) begin
            w  = 32'h13 | f_rd | (32'(i_f3[op-7]) << 12) | f_rs1 | f_i;
            ok = i_ok;
        end else if (op == 13) begin
            w  = 32'h03 | f_rd | (32'd2 << 12) | f_rs1 | f_i;
            ok = i_ok;
        end else if (op == 14) begin
            w  = 32'h23 | (32'd2 << 12) | f_rs1 | f_rs2 | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            ok = i_ok;
        end else if (op >= 15 && op <= 18) begin
            w  = 32'h63 | (32'(b_f3[op-15]) << 12) | f_rs1 | f_rs2 | bf;
            ok = (s >= -4096) && (s <= 4094) && !imm[0];
        end else if (op == 19) begin
            w  = 32'h6F | f_rd | jf;
            ok = (s >= -1048576) && (s <= 1048574) && !imm[0];
        end else if (op == 20) begin
            w  = 32'h67 | f_rd | f_rs1 | f_i;
            ok = i_ok;
        end else if (op == 21) begin
            w  = 32'h37 | f_rd | (imm & 32'hFFFF_F000);
            ok = ((imm & 32'hFFF) == 32'h0);
        end
    endfunction

    int bl [14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 31, 32};

    function automatic logic [31:0] rand_imm();
        logic [31:0] u;
        case ($urandom_range(0, 4))
            0: u = 32'($urandom_range(0, 40)) - 32'd20;
            1: u = 32'(bl[$urandom_range(0, 13)]);
            2: u = $urandom;
            3: begin u = $urandom; u[11:0] = 12'h0; end
            default: u = 32'($urandom_range(0, 10000)) - 32'd5000;
        endcase
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        ifa.op = 5'(op); ifa.rd = 5'(rd); ifa.rs1 = 5'(rs1); ifa.rs2 = 5'(rs2); ifa.imm = imm;
        ifa.in_valid = 1'b1;
    endtask

    task automatic drive_b(input int op, input int rd, input logic [31:0] imm);
        ifb.op = 5'(op); ifb.rd = 5'(rd); ifb.rs1 = 5'd1; ifb.rs2 = 5'd2; ifb.imm = imm;
        ifb.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.op = '0; ifa.rd = '0; ifa.rs1 = '0; ifa.rs2 = '0; ifa.imm = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.op = '0; ifb.rd = '0; ifb.rs1 = '0; ifb.rs2 = '0; ifb.imm = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) tick();
        checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_a got=%b exp=0", ifa.in_ready); end
        checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_b got=%b exp=0", ifb.in_ready); end
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", ifa.in_ready); end
        checks++; if ({ifa.out_valid, ifa.rej, ifa.err, ifa.full} !== 4'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {ifa.out_valid, ifa.rej, ifa.err, ifa.full}); end
        checks++; if (ifa.out_instr !== 32'h0 || ifa.out_addr !== 8'h0) begin
            failures++; $display("FAIL rst_word got=%h/%h exp=0/0", ifa.out_instr, ifa.out_addr); end
        tick();
    endtask

    int          d_op  [7] = '{0, 1, 7, 14, 21, 15, 19};
    int          d_rd  [7] = '{3, 3, 1, 0, 5, 0, 1};
    int          d_rs1 [7] = '{1, 1, 0, 1, 0, 1, 0};
    int          d_rs2 [7] = '{2, 2, 0, 2, 0, 2, 0};
    logic [31:0] d_imm [7] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8, 32'h1234_5000, 32'hFFFF_FFFC, 32'h8};
    logic [31:0] d_exp [7] = '{32'h002081B3, 32'h402081B3, 32'hFFF00093, 32'h0020A423,
                               32'h123452B7, 32'hFE208EE3, 32'h008000EF};

    task automatic test_directed();
        ifa.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_a(d_op[k], d_rd[k], d_rs1[k], d_rs2[k], d_imm[k]);
            #1;
            checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL dir_in_ready k=%0d got=%b exp=1", k, ifa.in_ready); end
            tick();
            checks++; if (ifa.out_valid !== 1'b1 || ifa.rej !== 1'b0 || ifa.err !== 1'b0) begin
                failures++; $display("FAIL dir_flags k=%0d valid/rej/err got=%b%b%b exp=100", k, ifa.out_valid, ifa.rej, ifa.err); end
            checks++; if (ifa.out_instr !== d_exp[k]) begin failures++; $display("FAIL dir_instr k=%0d got=%h exp=%h", k, ifa.out_instr, d_exp[k]); end
            checks++; if (ifa.out_addr !== 8'(next_addr_a)) begin failures++; $display("FAIL dir_addr k=%0d got=%0d exp=%0d", k, ifa.out_addr, next_addr_a); end
            next_addr_a++;
        end
        ifa.in_valid = 1'b0;
        tick();
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL dir_drain got=%b exp=0", ifa.out_valid); end
    endtask

    int          j_op  [4] = '{7, 15, 25, 10};
    logic [31:0] j_imm [4] = '{32'd2048, 32'd3, 32'd0, 32'd32};

    task automatic test_reject();
        logic [31:0] w; bit ok;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_a(j_op[i], 1, 2, 3, j_imm[i]);
            tick();
            ref_encode(0, i + 4, 1, 2, 32'h0, w, ok);
            drive_a(0, i + 4, 1, 2, 32'h0);
            checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL rej_no_word i=%0d got=%b exp=0", i, ifa.out_valid); end
            checks++; if (ifa.rej !== 1'b1 || ifa.err !== 1'b1) begin
                failures++; $display("FAIL rej_pulse i=%0d rej/err got=%b%b exp=11", i, ifa.rej, ifa.err); end
            tick();
            ifa.in_valid = 1'b0;
            checks++; if (ifa.rej !== 1'b0 || ifa.err !== 1'b1) begin
                failures++; $display("FAIL rej_end i=%0d rej/err got=%b%b exp=01", i, ifa.rej, ifa.err); end
            checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== w || ifa.out_addr !== 8'(next_addr_a)) begin
                failures++; $display("FAIL rej_next i=%0d got=%b/%h/%0d exp=1/%h/%0d", i, ifa.out_valid, ifa.out_instr, ifa.out_addr, w, next_addr_a); end
            next_addr_a++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ifa.out_ready = 1'b1;
        drive_a(2, 7, 5, 6, 32'h0);
        tick();
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_addr !== 8'(next_addr_a)) begin
            failures++; $display("FAIL b2b_first got=%b/%0d exp=1/%0d", ifa.out_valid, ifa.out_addr, next_addr_a); end
        next_addr_a++;
        drive_a(30, 1, 1, 1, 32'h0);
        tick();
        checks++; if (ifa.out_valid !== 1'b0 || ifa.rej !== 1'b1) begin
            failures++; $display("FAIL b2b_rej_drain valid/rej got=%b%b exp=01", ifa.out_valid, ifa.rej); end
        drive_a(19, 1, 0, 0, 32'h3);
        tick();
        checks++; if (ifa.out_valid !== 1'b0 || ifa.rej !== 1'b1) begin
            failures++; $display("FAIL b2b_rej2 valid/rej got=%b%b exp=01", ifa.out_valid, ifa.rej); end
        drive_a(3, 8, 9, 10, 32'h0);
        tick();
        checks++; if (ifa.out_valid !== 1'b1 || ifa.rej !== 1'b0 || ifa.out_addr !== 8'(next_addr_a)) begin
            failures++; $display("FAIL b2b_last valid/rej/addr got=%b%b/%0d exp=10/%0d", ifa.out_valid, ifa.rej, ifa.out_addr, next_addr_a); end
        next_addr_a++;
        ifa.in_valid = 1'b0;
        tick();
        checks++; if (ifa.out_valid !== 1'b0 || ifa.rej !== 1'b0) begin
            failures++; $display("FAIL b2b_idle valid/rej got=%b%b exp=00", ifa.out_valid, ifa.rej); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w1, w2; bit ok;
        ref_encode(4, 11, 12, 13, 32'h0, w1, ok);
        ref_encode(8, 14, 15, 0, 32'h123, w2, ok);
        ifa.out_ready = 1'b0;
        drive_a(4, 11, 12, 13, 32'h0);
        tick();
        drive_a(8, 14, 15, 0, 32'h123);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, ifa.in_ready); end
            checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== w1 || ifa.out_addr !== 8'(next_addr_a)) begin
                failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/%h/%0d", c, ifa.out_valid, ifa.out_instr, ifa.out_addr, w1, next_addr_a); end
            tick();
        end
        ifa.out_ready = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ifa.in_ready); end
        tick();
        next_addr_a++;
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_valid !== 1'b1 || ifa.out_instr !== w2 || ifa.out_addr !== 8'(next_addr_a)) begin
            failures++; $display("FAIL bp_second got=%b/%h/%0d exp=1/%h/%0d", ifa.out_valid, ifa.out_instr, ifa.out_addr, w2, next_addr_a); end
        next_addr_a++;
        tick();
        checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", ifa.out_valid); end
    endtask

    task automatic test_random();
        bit pv = 1'b0; bit rej_e = 1'b0; bit err_e = 1'b1;
        logic [31:0] p_instr = 32'h0; int p_addr = 0; int cnt = next_addr_a;
        logic [31:0] w, imm; bit ok, exp_ready, acc, iv; int op, rd, rs1, rs2;
        for (int c = 0; c < 300; c++) begin
            iv = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 26); rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
            imm = rand_imm();
            drive_a(op, rd, rs1, rs2, imm);
            ifa.in_valid = iv;
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (cnt < 256) && (!pv || ifa.out_ready);
            checks++; if (ifa.in_ready !== exp_ready) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, ifa.in_ready, exp_ready); end
            checks++; if (ifa.out_valid !== pv) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ifa.out_valid, pv); end
            if (pv) begin
                checks++; if (ifa.out_instr !== p_instr || ifa.out_addr !== 8'(p_addr)) begin
                    failures++; $display("FAIL rnd_word c=%0d got=%h/%0d exp=%h/%0d", c, ifa.out_instr, ifa.out_addr, p_instr, p_addr); end
            end
            checks++; if (ifa.rej !== rej_e || ifa.err !== err_e || ifa.full !== (cnt == 256)) begin
                failures++; $display("FAIL rnd_flags c=%0d rej/err/full got=%b%b%b exp=%b%b%b", c, ifa.rej, ifa.err, ifa.full, rej_e, err_e, cnt == 256); end
            ref_encode(op, rd, rs1, rs2, imm, w, ok);
            acc   = iv && exp_ready;
            rej_e = acc && !ok;
            if (rej_e) err_e = 1'b1;
            if (acc && ok) begin pv = 1'b1; p_instr = w; p_addr = cnt; cnt++; end
            else if (pv && ifa.out_ready) pv = 1'b0;
            tick();
        end
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        repeat (2) tick();
        next_addr_a = cnt;
    endtask

    task automatic test_full();
        ifb.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_b(0, i + 1, 32'h0);
            #1;
            checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL full_ready i=%0d got=%b exp=1", i, ifb.in_ready); end
            tick();
            checks++; if (ifb.out_valid !== 1'b1 || ifb.out_addr !== 2'(i) || ifb.full !== (i == 3)) begin
                failures++; $display("FAIL full_word i=%0d valid/addr/full got=%b/%0d/%b exp=1/%0d/%b", i, ifb.out_valid, ifb.out_addr, ifb.full, i, i == 3); end
        end
        drive_b(0, 9, 32'h0);
        #1;
        checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", ifb.in_ready); end
        tick();
        checks++; if (ifb.out_valid !== 1'b0 || ifb.full !== 1'b1 || ifb.in_ready !== 1'b0) begin
            failures++; $display("FAIL full_after valid/full/ready got=%b%b%b exp=010", ifb.out_valid, ifb.full, ifb.in_ready); end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        ifb.in_valid = 1'b0;
        checks++; if (ifb.full !== 1'b0 || ifb.out_valid !== 1'b0) begin
            failures++; $display("FAIL full_rst full/valid got=%b%b exp=00", ifb.full, ifb.out_valid); end
        drive_b(25, 1, 32'h0);
        tick();
        ifb.out_ready = 1'b0;
        drive_b(1, 2, 32'h0);
        tick();
        ifb.in_valid = 1'b0;
        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_addr !== 2'd0 || ifb.err !== 1'b1) begin
            failures++; $display("FAIL mid_pending valid/addr/err got=%b/%0d/%b exp=1/0/1", ifb.out_valid, ifb.out_addr, ifb.err); end
        rst_b = 1'b1;
        #1;
        checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", ifb.in_ready); end
        tick();
        checks++; if ({ifb.out_valid, ifb.full, ifb.err, ifb.rej} !== 4'b0) begin
            failures++; $display("FAIL mid_rst_flags got=%b exp=0000", {ifb.out_valid, ifb.full, ifb.err, ifb.rej}); end
        rst_b = 1'b0;
        ifb.out_ready = 1'b1;
        drive_b(2, 3, 32'h0);
        #1;
        checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL mid_post_ready got=%b exp=1", ifb.in_ready); end
        tick();
        checks++; if (ifb.out_valid !== 1'b1 || ifb.out_addr !== 2'd0) begin
            failures++; $display("FAIL mid_post_addr got=%b/%0d exp=1/0", ifb.out_valid, ifb.out_addr); end
        ifb.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reject();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
